// File: rtl/axis_upsizer_pkg.sv
// axis_pkg: shared constants and helpers for the AXIS upsizer slice.
package axis_pkg;
  localparam int PKT_CNT_W = 32;
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++) if ((1 << r) >= v) return r;
    return 32;
  endfunction
endpackage

// File: rtl/axis_upsizer_if.sv
// axis_upsizer_if: narrow slave stream plus wide master stream of the upsizer.
interface axis_upsizer_if #(parameter int DATA_WIDTH = 32, parameter int RATIO = 4);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic s_axis_tvalid;
  logic s_axis_tready;
  logic s_axis_tlast;
  logic [DATA_WIDTH*RATIO-1:0] m_axis_tdata;
  logic [RATIO-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tready;
  logic m_axis_tlast;
  // slave: the upsizer itself; master: the environment driving it
  modport slave (input s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
                 output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast);
  modport master (output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
                  input s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast);
endinterface

// File: rtl/axis_upsizer_out_reg.sv
// axis_upsizer_out_reg: registered output stage {tlast, tkeep, tdata} with valid/ready.
module axis_upsizer_out_reg #(parameter int DW = 128, parameter int KW = 4) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          load,
  input  logic [DW-1:0] d_data,
  input  logic [KW-1:0] d_keep,
  input  logic          d_last,
  input  logic          q_ready,
  output logic          q_valid,
  output logic [DW-1:0] q_data,
  output logic [KW-1:0] q_keep,
  output logic          q_last,
  output logic          up_ready
);
  assign up_ready = aresetn && (!q_valid || q_ready);
  always_ff @(posedge aclk)
    if (!aresetn) begin
      q_valid <= 1'b0;
      q_keep  <= '0;
      q_last  <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_keep  <= d_keep;
      q_last  <= d_last;
    end else if (q_ready) q_valid <= 1'b0;
  // data is not reset; it is only meaningful while q_valid is high
  always_ff @(posedge aclk) if (load) q_data <= d_data;
endmodule

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO narrow AXIS beats into one wide beat, tlast flushes a partial word.
// Define AXIS_UPSIZER_PKT_CNT_EN to add the 32-bit pkt_count output.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input logic aclk,
  input logic aresetn,
  axis_upsizer_if.slave bus
`ifdef AXIS_UPSIZER_PKT_CNT_EN
  , output logic [PKT_CNT_W-1:0] pkt_count
`endif
);
  localparam int IW = clog2(RATIO);
  localparam int WW = DATA_WIDTH * RATIO;
  logic [IW-1:0] idx;
  logic [RATIO-2:0] acc_keep;
  logic [DATA_WIDTH-1:0] acc [RATIO-1];
  logic in_fire;
  logic complete;
  logic [WW-1:0] wide_data;
  logic [RATIO-1:0] wide_keep;
  assign in_fire  = bus.s_axis_tvalid && bus.s_axis_tready;
  assign complete = in_fire && (idx == IW'(RATIO - 1) || bus.s_axis_tlast);
  // lanes below idx come from acc, lane idx is the live beat, lanes above are zero
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    if (k < RATIO - 1) begin : g_acc
      assign wide_data[k*DATA_WIDTH +: DATA_WIDTH] = IW'(k) < idx ? acc[k] :
                                                     IW'(k) == idx ? bus.s_axis_tdata : '0;
      assign wide_keep[k] = IW'(k) < idx ? acc_keep[k] : IW'(k) == idx;
    end else begin : g_top
      assign wide_data[k*DATA_WIDTH +: DATA_WIDTH] = IW'(k) == idx ? bus.s_axis_tdata : '0;
      assign wide_keep[k] = IW'(k) == idx;
    end
  end
  always_ff @(posedge aclk)
    if (!aresetn) begin
      idx      <= '0;
      acc_keep <= '0;
    end else if (complete) begin
      idx      <= '0;
      acc_keep <= '0;
    end else if (in_fire) begin
      idx <= idx + 1'b1;
      for (int k = 0; k < RATIO - 1; k++) if (IW'(k) == idx) acc_keep[k] <= 1'b1;
    end
  always_ff @(posedge aclk)
    if (in_fire && !complete)
      for (int k = 0; k < RATIO - 1; k++) if (IW'(k) == idx) acc[k] <= bus.s_axis_tdata;
  axis_upsizer_out_reg #(.DW(WW), .KW(RATIO)) u_out (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .load     (complete),
    .d_data   (wide_data),
    .d_keep   (wide_keep),
    .d_last   (bus.s_axis_tlast),
    .q_ready  (bus.m_axis_tready),
    .q_valid  (bus.m_axis_tvalid),
    .q_data   (bus.m_axis_tdata),
    .q_keep   (bus.m_axis_tkeep),
    .q_last   (bus.m_axis_tlast),
    .up_ready (bus.s_axis_tready)
  );
`ifdef AXIS_UPSIZER_PKT_CNT_EN
  always_ff @(posedge aclk)
    if (!aresetn) pkt_count <= '0;
    else if (bus.m_axis_tvalid && bus.m_axis_tready && bus.m_axis_tlast) pkt_count <= pkt_count + 1'b1;
`endif
endmodule

// File: tb/tb_axis_upsizer.sv
// tb_axis_upsizer: randomized self-checking bench with a packet-level reference model.
module tb_axis_upsizer;
  typedef struct packed {
    logic         last;
    logic [3:0]   keep;
    logic [127:0] data;
  } wbeat_t;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int total = 0;
  int bad = 0;
  int stalls = 0;
  bit rand_rdy = 0;
  bit in_taken = 0;
  logic [31:0] grp[$];
  wbeat_t exp_q[$];
  wbeat_t got_q[$];
  axis_upsizer_if #(.DATA_WIDTH(32), .RATIO(4)) bus ();
`ifdef AXIS_UPSIZER_PKT_CNT_EN
  logic [31:0] pkt_count;
`endif
  axis_upsizer #(.DATA_WIDTH(32), .RATIO(4)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
`ifdef AXIS_UPSIZER_PKT_CNT_EN
    , .pkt_count (pkt_count)
`endif
  );
  always #5 aclk = ~aclk;

  function automatic void model_push(input logic [31:0] d, input logic l);
    wbeat_t w;
    grp.push_back(d);
    if (grp.size() == 4 || l) begin
      w.data = '0;
      foreach (grp[i]) w.data[i*32 +: 32] = grp[i];
      w.keep = 4'((1 << grp.size()) - 1);
      w.last = l;
      exp_q.push_back(w);
      grp.delete();
    end
  endfunction

  task automatic step();
    if (rand_rdy) bus.m_axis_tready = 1'($urandom_range(0, 1));
    #1;
    in_taken = 0;
    if (!aresetn) begin
      grp.delete();
      exp_q.delete();
      got_q.delete();
    end else begin
      if (bus.m_axis_tvalid && bus.m_axis_tready)
        got_q.push_back({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata});
      if (bus.s_axis_tvalid && !bus.s_axis_tready) stalls++;
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        in_taken = 1;
        model_push(bus.s_axis_tdata, bus.s_axis_tlast);
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    do begin
      step();
      n++;
    end while (!in_taken && n < 500);
    total++;
    if (!in_taken) begin
      bad++;
      $display("FAIL send_timeout got=not_accepted exp=accepted data=%h", d);
    end
  endtask

  task automatic drain();
    bus.s_axis_tvalid = 1'b0;
    rand_rdy = 0;
    bus.m_axis_tready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.s_axis_tdata = '0;
    bus.m_axis_tready = 1'b1;
    step();
    step();
    total += 4;
    if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", bus.m_axis_tvalid); end
    if (bus.m_axis_tkeep !== 4'b0) begin bad++; $display("FAIL rst_tkeep got=%b exp=0000", bus.m_axis_tkeep); end
    if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", bus.m_axis_tlast); end
    if (bus.s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_sready got=%b exp=0", bus.s_axis_tready); end
    aresetn = 1'b1;
    step();
    total += 2;
    if (bus.s_axis_tready !== 1'b1) begin bad++; $display("FAIL post_rst_sready got=%b exp=1", bus.s_axis_tready); end
    if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL post_rst_tvalid got=%b exp=0", bus.m_axis_tvalid); end
  endtask

  task automatic test_full_group();
    bus.m_axis_tready = 1'b1;
    send(32'h11, 0);
    send(32'h22, 0);
    send(32'h33, 0);
    send(32'h44, 1);
    total += 4;
    if (bus.m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL full_tvalid got=%b exp=1", bus.m_axis_tvalid); end
    if (bus.m_axis_tdata !== 128'h00000044_00000033_00000022_00000011) begin
      bad++; $display("FAIL full_tdata got=%h exp=00000044000000330000002200000011", bus.m_axis_tdata);
    end
    if (bus.m_axis_tkeep !== 4'b1111) begin bad++; $display("FAIL full_tkeep got=%b exp=1111", bus.m_axis_tkeep); end
    if (bus.m_axis_tlast !== 1'b1) begin bad++; $display("FAIL full_tlast got=%b exp=1", bus.m_axis_tlast); end
    drain();
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL full_count got=%0d exp=1", got_q.size());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_partial();
    bus.m_axis_tready = 1'b1;
    send(32'hA, 0);
    send(32'hB, 1);
    total += 3;
    if (bus.m_axis_tdata !== 128'h0000000B_0000000A) begin
      bad++; $display("FAIL part_tdata got=%h exp=0000000b0000000a", bus.m_axis_tdata);
    end
    if (bus.m_axis_tkeep !== 4'b0011) begin bad++; $display("FAIL part_tkeep got=%b exp=0011", bus.m_axis_tkeep); end
    if (bus.m_axis_tlast !== 1'b1) begin bad++; $display("FAIL part_tlast got=%b exp=1", bus.m_axis_tlast); end
    send(32'hC, 1);
    total += 2;
    if (bus.m_axis_tdata !== 128'hC) begin bad++; $display("FAIL single_tdata got=%h exp=c", bus.m_axis_tdata); end
    if (bus.m_axis_tkeep !== 4'b0001) begin bad++; $display("FAIL single_tkeep got=%b exp=0001", bus.m_axis_tkeep); end
    drain();
    total++;
    if (got_q.size() != 2 || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL part_count got=%0d exp=2", got_q.size());
    end else foreach (got_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL part_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_pressure();
    wbeat_t snap;
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, 0);
    snap = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
    bus.s_axis_tdata = $urandom;
    bus.s_axis_tlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total += 2;
      if (bus.s_axis_tready !== 1'b0) begin bad++; $display("FAIL bp_sready c%0d got=%b exp=0", i, bus.s_axis_tready); end
      if ({bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} !== snap || bus.m_axis_tvalid !== 1'b1) begin
        bad++; $display("FAIL bp_stable c%0d got=%h exp=%h", i, {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata}, snap);
      end
    end
    bus.m_axis_tready = 1'b1;
    send(bus.s_axis_tdata, 0);
    for (int i = 0; i < 7; i++) send($urandom, i == 6);
    drain();
    total++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      bad++; $display("FAIL bp_count got=%0d exp=3", got_q.size());
    end else foreach (got_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_stream();
    stalls = 0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 64; i++) send($urandom, i % 8 == 7);
    drain();
    total += 2;
    if (stalls !== 0) begin bad++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
    if (got_q.size() != 16 || exp_q.size() != 16) begin
      bad++; $display("FAIL stream_count got=%0d exp=16", got_q.size());
    end else foreach (got_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.s_axis_tvalid = 1'b0;
        step();
      end
      send($urandom, $urandom_range(0, 5) == 0 || i == 299);
    end
    drain();
    total++;
    if (got_q.size() != exp_q.size() || got_q.size() == 0) begin
      bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else foreach (got_q[i]) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send($urandom, 0);
    bus.s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    bus.m_axis_tready = 1'b1;
    step();
    step();
    total += 2;
    if (got_q.size() != 0) begin bad++; $display("FAIL rst_pending_out got=%0d exp=0", got_q.size()); end
    if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rst_pending_tvalid got=%b exp=0", bus.m_axis_tvalid); end
    send(32'hDEAD0001, 0);
    send(32'hDEAD0002, 0);
    bus.s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    step();
    total += 2;
    if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b exp=0", bus.m_axis_tvalid); end
    if (bus.s_axis_tready !== 1'b0) begin bad++; $display("FAIL rstmid_sready got=%b exp=0", bus.s_axis_tready); end
    aresetn = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'h100 + i, 0);
    total += 3;
    if (bus.m_axis_tkeep !== 4'b1111) begin bad++; $display("FAIL rstmid_tkeep got=%b exp=1111", bus.m_axis_tkeep); end
    if (bus.m_axis_tdata !== 128'h00000104_00000103_00000102_00000101) begin
      bad++; $display("FAIL rstmid_tdata got=%h exp=00000104000001030000010200000101", bus.m_axis_tdata);
    end
    if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rstmid_tlast got=%b exp=0", bus.m_axis_tlast); end
    drain();
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size());
    end
    got_q.delete();
    exp_q.delete();
  endtask

`ifdef AXIS_UPSIZER_PKT_CNT_EN
  task automatic test_pkt_cnt();
    int lens[5] = '{1, 3, 4, 5, 9};
    aresetn = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    total++;
    if (pkt_count !== 32'd0) begin bad++; $display("FAIL cnt_reset got=%0d exp=0", pkt_count); end
    bus.m_axis_tready = 1'b1;
    foreach (lens[p]) for (int i = 0; i < lens[p]; i++) send($urandom, i == lens[p] - 1);
    drain();
    total++;
    if (pkt_count !== 32'd5) begin bad++; $display("FAIL cnt_five got=%0d exp=5", pkt_count); end
    got_q.delete();
    exp_q.delete();
  endtask
`endif

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.s_axis_tdata = '0;
    bus.m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    test_reset();
    test_full_group();
    test_partial();
    test_back_pressure();
    test_stream();
    test_random();
    test_reset_mid();
`ifdef AXIS_UPSIZER_PKT_CNT_EN
    test_pkt_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- AXI-Stream width upsizer that packs RATIO consecutive narrow beats into one wide beat.
- Sits directly downstream of the single-register AXIS prefetch stage and consumes its m_axis output.
- Honours packet boundaries: s_axis_tlast flushes a partial wide word, with per-lane tkeep marking the valid lanes.
- Output is fully registered; s_axis_tready depends only on output-register state, never on s_axis_tvalid.

Parameters:
- DATA_WIDTH, 32, width of one narrow input beat in bits.
- RATIO, 4, number of narrow lanes per output beat; legal range 2..16.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  reset, synchronous, active-low.
- s_axis_tdata  input  DATA_WIDTH  narrow input data.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high with tvalid.
- s_axis_tlast  input  1  last narrow beat of packet.
- m_axis_tdata  output  DATA_WIDTH*RATIO  packed wide data; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_axis_tkeep  output  RATIO  per-lane valid flag, lane granularity.
- m_axis_tvalid  output  1  wide beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  wide beat ends a packet.

Behaviour:
- Definitions:
  - in_fire = s_axis_tvalid && s_axis_tready.
  - out_fire = m_axis_tvalid && m_axis_tready.
- Ready rule: s_axis_tready = aresetn ? (!m_axis_tvalid || m_axis_tready) : 0. It is forced low while in reset.
- State:
  - lane index idx, width clog2(RATIO), counts 0..RATIO-1.
  - accumulator acc holds lanes 0..RATIO-2 plus keep bits acc_keep.
  - output register holds {tlast, tkeep, tdata} and valid_o.
- Lane order: the first beat of a group goes to lane 0 (LSBs); subsequent beats fill ascending lanes.
- in_fire with idx < RATIO-1 and !s_axis_tlast:
  - write the beat into lane idx of acc and set acc_keep[idx].
  - idx <= idx+1.
- Completion: in_fire with idx == RATIO-1, or with s_axis_tlast at any idx.
  - Output register loads acc lanes below idx, s_axis_tdata in lane idx, and zeros in lanes above idx.
  - tkeep = acc_keep with bit idx set and higher bits clear.
  - tlast = s_axis_tlast.
  - valid_o <= 1; idx <= 0; acc_keep <= 0.
- valid_o clears on out_fire when there is no completion in the same cycle. Completion and out_fire in the same cycle reload the register and keep valid_o = 1.
- Latency: one cycle from the completing input beat to m_axis_tvalid.
- Throughput: one narrow beat per cycle when m_axis_tready is held high.
- Stalls: under back-pressure s_axis_tready drops while valid_o && !m_axis_tready, including mid-group. This is accepted behaviour; acc and idx hold.
- tlast with RATIO-1 == idx produces a full word with tkeep all-ones and tlast = 1.
- A single-beat packet (tlast at idx 0) produces tkeep = 1 and lane 0 only.
- Reset values:
  - m_axis_tvalid = 0, m_axis_tkeep = 0, m_axis_tlast = 0.
  - idx = 0, acc_keep = 0.
  - m_axis_tdata and acc data are not reset.
- Reset mid-packet discards the partial group and any pending output beat. No output is generated for the discarded data after reset.
- Stability: m_axis_tdata, tkeep and tlast stay stable while m_axis_tvalid && !m_axis_tready.

Optional Feature:
- Macro AXIS_UPSIZER_PKT_CNT_EN.
- Defined:
  - Adds output port pkt_count, 32 bits.
  - Increments on every out_fire with m_axis_tlast = 1 and wraps 0xFFFFFFFF -> 0.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package axis_pkg:
  - clog2 constant function for lane-index width.
  - localparam for the packet-counter width (32).
- One sub-module: axis_upsizer_out_reg. It is the registered output stage holding {tlast, tkeep, tdata} and the valid/ready logic, parameterised on total width.

Test Plan:
- Single full group: RATIO=4 beats 0x11,0x22,0x33,0x44 (last on 4th), m_tready=1 -> one beat, tdata=0x00000044_00000033_00000022_00000011, tkeep=4'b1111, tlast=1, one cycle after the 4th beat.
- Partial flush: 0xA,0xB with tlast on the 2nd -> tdata upper two lanes 0, tkeep=4'b0011, tlast=1; the next packet starts at lane 0.
- Back-pressure: hold m_tready=0 after the first wide beat completes -> s_tready=0 and output stable for 10 cycles; release -> no lost or duplicated beats across 3 groups.
- Continuous stream: 64 beats at tvalid=1, m_tready=1, tlast every 8 -> 16 wide beats, zero input stall cycles after the first group.
- Reset mid-packet: 2 beats accepted, aresetn low 1 cycle -> m_tvalid=0, s_tready=0 during reset; next 4 beats form a clean word with tkeep=4'b1111.
- With AXIS_UPSIZER_PKT_CNT_EN: 5 packets of lengths 1,3,4,5,9 -> pkt_count=5 after the last tlast out_fire; preload 0xFFFFFFFF, one more packet -> 0.
